// File: rtl/register_writeback_bank_if.sv
// Bus bundle for register_writeback_bank: one write-request port, two read ports
// and the writeback status flags.
interface register_writeback_bank_if;
  // Handshake: there is no ready. Every write request with reg_write=1 and
  // write_addr!=0 is accepted at the rising edge where it is sampled. Read ports
  // are purely combinational. wb_pending/wb_commit are status only.
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr_a;
  logic [4:0]  read_addr_b;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic        wb_pending;
  logic        wb_commit;

  modport master (
    output reg_write,
    output write_addr,
    output write_data,
    output read_addr_a,
    output read_addr_b,
    input  read_data_a,
    input  read_data_b,
    input  wb_pending,
    input  wb_commit
  );

  modport slave (
    input  reg_write,
    input  write_addr,
    input  write_data,
    input  read_addr_a,
    input  read_addr_b,
    output read_data_a,
    output read_data_b,
    output wb_pending,
    output wb_commit
  );
endinterface

// File: rtl/register_writeback_bank.sv
// 32x32 register bank with a one-entry writeback staging buffer (capture, then commit).
// Optional macro REGBANK_BYPASS_EN forwards the staged write to the read ports.
module register_writeback_bank (
  input  logic                          clk,
  input  logic                          reset,
  register_writeback_bank_if.slave      bus
);
  localparam int unsigned NREGS   = 32;
  localparam int          SP_IDX  = 29;
  localparam logic [31:0] SP_INIT = 32'd227;

  logic [31:0] regs [NREGS];
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic [31:0] pend_data;
  logic        wb_commit_q;
  logic        capture;

  // Writes to register 0 are dropped here, so pend_addr is never 0 while valid.
  assign capture = bus.reg_write && (bus.write_addr != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid  <= 1'b0;
      pend_addr   <= 5'd0;
      pend_data   <= 32'd0;
      wb_commit_q <= 1'b0;
    end else begin
      pend_valid  <= capture;
      wb_commit_q <= pend_valid;
      if (capture) begin
        pend_addr <= bus.write_addr;
        pend_data <= bus.write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : 32'd0;
      end
    end else if (pend_valid) begin
      regs[pend_addr] <= pend_data;
    end
  end

  always_comb begin
    bus.read_data_a = 32'd0;
    if (bus.read_addr_a != 5'd0) begin
      bus.read_data_a = regs[bus.read_addr_a];
`ifdef REGBANK_BYPASS_EN
      if (pend_valid && (bus.read_addr_a == pend_addr)) begin
        bus.read_data_a = pend_data;
      end
`endif
    end
  end

  always_comb begin
    bus.read_data_b = 32'd0;
    if (bus.read_addr_b != 5'd0) begin
      bus.read_data_b = regs[bus.read_addr_b];
`ifdef REGBANK_BYPASS_EN
      if (pend_valid && (bus.read_addr_b == pend_addr)) begin
        bus.read_data_b = pend_data;
      end
`endif
    end
  end

  assign bus.wb_pending = pend_valid;
  assign bus.wb_commit  = wb_commit_q;
endmodule

// File: tb/tb_register_writeback_bank.sv
// Directed self-checking bench for register_writeback_bank; expectations follow
// REGBANK_BYPASS_EN so the same bench covers both builds.
module tb_register_writeback_bank;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  register_writeback_bank_if bus ();

  register_writeback_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic we, input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.reg_write  = we;
    bus.write_addr = addr;
    bus.write_data = data;
  endtask

  task automatic drive_idle();
    bus.reg_write  = 1'b0;
    bus.write_addr = 5'd0;
    bus.write_data = 32'd0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    bus.read_addr_a = 5'd29;
    bus.read_addr_b = 5'd5;
    tick();
    tick();
    n_checks++;
    if (bus.read_data_a !== 32'd227) begin
      n_fail++;
      $display("FAIL reset_sp: got %0d expected 227", bus.read_data_a);
    end
    n_checks++;
    if (bus.read_data_b !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_r5: got %h expected 0", bus.read_data_b);
    end
    n_checks++;
    if (bus.wb_pending !== 1'b0 || bus.wb_commit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: pending=%b commit=%b expected 0 0", bus.wb_pending, bus.wb_commit);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.read_data_a !== 32'd227 || bus.wb_pending !== 1'b0 || bus.wb_commit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: r29=%0d pending=%b commit=%b expected 227 0 0",
               bus.read_data_a, bus.wb_pending, bus.wb_commit);
    end
  endtask

  task automatic test_single_write();
    logic [31:0] exp_n;
    bus.read_addr_a = 5'd8;
    drive_write(1'b1, 5'd8, 32'hDEADBEEF);
    tick();  // edge N
    drive_idle();
    exp_n = BYPASS ? 32'hDEADBEEF : 32'd0;
    n_checks++;
    if (bus.wb_pending !== 1'b1 || bus.wb_commit !== 1'b0) begin
      n_fail++;
      $display("FAIL single_flags_n: pending=%b commit=%b expected 1 0", bus.wb_pending, bus.wb_commit);
    end
    n_checks++;
    if (bus.read_data_a !== exp_n) begin
      n_fail++;
      $display("FAIL single_read_n: got %h expected %h", bus.read_data_a, exp_n);
    end
    tick();  // edge N+1
    n_checks++;
    if (bus.wb_pending !== 1'b0 || bus.wb_commit !== 1'b1) begin
      n_fail++;
      $display("FAIL single_flags_n1: pending=%b commit=%b expected 0 1", bus.wb_pending, bus.wb_commit);
    end
    n_checks++;
    if (bus.read_data_a !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_read_n1: got %h expected deadbeef", bus.read_data_a);
    end
    tick();  // edge N+2
    n_checks++;
    if (bus.wb_commit !== 1'b0 || bus.read_data_a !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_n2: commit=%b data=%h expected 0 deadbeef", bus.wb_commit, bus.read_data_a);
    end
  endtask

  task automatic test_reg0();
    bus.read_addr_a = 5'd0;
    bus.read_addr_b = 5'd0;
    drive_write(1'b1, 5'd0, 32'h1234);
    tick();
    drive_idle();
    n_checks++;
    if (bus.wb_pending !== 1'b0 || bus.read_data_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reg0_n: pending=%b data=%h expected 0 0", bus.wb_pending, bus.read_data_a);
    end
    tick();
    n_checks++;
    if (bus.wb_commit !== 1'b0 || bus.read_data_b !== 32'd0) begin
      n_fail++;
      $display("FAIL reg0_n1: commit=%b data=%h expected 0 0", bus.wb_commit, bus.read_data_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_n, exp_n1;
    bus.read_addr_a = 5'd3;
    bus.read_addr_b = 5'd3;
    drive_write(1'b1, 5'd3, 32'd1);
    tick();  // edge N
    exp_n = BYPASS ? 32'd1 : 32'd0;
    n_checks++;
    if (bus.read_data_a !== exp_n) begin
      n_fail++;
      $display("FAIL b2b_read_n: got %h expected %h", bus.read_data_a, exp_n);
    end
    drive_write(1'b1, 5'd3, 32'd2);
    tick();  // edge N+1
    drive_idle();
    exp_n1 = BYPASS ? 32'd2 : 32'd1;
    n_checks++;
    if (bus.read_data_b !== exp_n1 || bus.wb_commit !== 1'b1 || bus.wb_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_n1: data=%h commit=%b pending=%b expected %h 1 1",
               bus.read_data_b, bus.wb_commit, bus.wb_pending, exp_n1);
    end
    tick();  // edge N+2
    n_checks++;
    if (bus.read_data_a !== 32'd2 || bus.wb_commit !== 1'b1 || bus.wb_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_n2: data=%h commit=%b pending=%b expected 2 1 0",
               bus.read_data_a, bus.wb_commit, bus.wb_pending);
    end
    tick();
    n_checks++;
    if (bus.wb_commit !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_n3: commit=%b expected 0", bus.wb_commit);
    end
  endtask

  task automatic test_dual_read();
    logic [31:0] exp_n;
    bus.read_addr_a = 5'd29;
    bus.read_addr_b = 5'd29;
    drive_write(1'b1, 5'd29, 32'd5);
    tick();
    drive_idle();
    exp_n = BYPASS ? 32'd5 : 32'd227;
    n_checks++;
    if (bus.read_data_a !== exp_n || bus.read_data_b !== exp_n) begin
      n_fail++;
      $display("FAIL dual_n: a=%0d b=%0d expected %0d", bus.read_data_a, bus.read_data_b, exp_n);
    end
    tick();
    n_checks++;
    if (bus.read_data_a !== 32'd5 || bus.read_data_b !== 32'd5) begin
      n_fail++;
      $display("FAIL dual_n1: a=%0d b=%0d expected 5", bus.read_data_a, bus.read_data_b);
    end
  endtask

  task automatic test_reset_mid();
    bus.read_addr_a = 5'd10;
    bus.read_addr_b = 5'd29;
    drive_write(1'b1, 5'd10, 32'hAA);
    tick();  // edge N: staged
    drive_idle();
    n_checks++;
    if (bus.wb_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_staged: pending=%b expected 1", bus.wb_pending);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.wb_pending !== 1'b0 || bus.read_data_b !== 32'd227) begin
      n_fail++;
      $display("FAIL rmid_async: pending=%b r29=%0d expected 0 227", bus.wb_pending, bus.read_data_b);
    end
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.read_data_a !== 32'd0 || bus.wb_commit !== 1'b0 || bus.wb_pending !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_after_%0d: r10=%h commit=%b pending=%b expected 0 0 0",
                 k, bus.read_data_a, bus.wb_commit, bus.wb_pending);
      end
    end
  endtask

  // Streams one write per cycle to every register, then reads all back on both ports.
  task automatic test_fill();
    logic [31:0] exp_q[$];
    logic [31:0] exp_a, exp_b;
    logic [4:0]  ra, rb;
    for (int a = 1; a < 32; a++) begin
      drive_write(1'b1, 5'(a), 32'hC0DE_0000 | 32'(a));
    end
    drive_write(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    exp_q.push_back(32'd0);
    for (int a = 1; a < 32; a++) exp_q.push_back(32'hC0DE_0000 | 32'(a));
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a);
      rb = 5'(31 - a);
      bus.read_addr_a = ra;
      bus.read_addr_b = rb;
      #1;
      exp_a = exp_q[a];
      exp_b = exp_q[31 - a];
      n_checks++;
      if (bus.read_data_a !== exp_a || bus.read_data_b !== exp_b) begin
        n_fail++;
        $display("FAIL fill_r%0d_r%0d: a=%h b=%h expected %h %h",
                 ra, rb, bus.read_data_a, bus.read_data_b, exp_a, exp_b);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive_idle();
    bus.read_addr_a = 5'd0;
    bus.read_addr_b = 5'd0;
    test_reset();
    test_single_write();
    test_reg0();
    test_back_to_back();
    test_dual_read();
    test_reset_mid();
    test_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
